addr_stepper: RTL

Parametrised address sequencer for the memory-display datapath. It walks a read address through a DEPTH-entry memory at a programmable rate and drives the 7-segment and LED logic. User controls are pause, stepped speed-up/speed-down over NUM_SPEEDS rate levels, a run direction, and a wrap/stop end mode. It sits between the board push-buttons/switches and the instruction/data memory address port inside top.

---
 rtl/addr_stepper_pkg.sv | 17 +
 rtl/btn_sync_edge.sv | 16 +
 rtl/addr_stepper.sv | 91 +++++++++
 3 files changed

// File: rtl/addr_stepper_pkg.sv
// addr_stepper_pkg: shared constants, direction encoding and width helper for addr_stepper.
package addr_stepper_pkg;
    localparam int DEF_ADDR_W        = 8;
    localparam int DEF_DEPTH         = 256;
    localparam int DEF_NUM_SPEEDS    = 4;
    localparam int DEF_DEFAULT_SPEED = 1;
    localparam int DEF_BASE_TICKS    = 50000000;
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;
    // never returns 0 so that derived vectors stay at least one bit wide
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction
endpackage

// File: rtl/btn_sync_edge.sv
// btn_sync_edge: 2-FF synchroniser with a rising-edge strobe, one event per low-to-high transition.
module btn_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_level,
    output logic o_rise
);
    logic r_meta, r_sync, r_prev;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) {r_meta, r_sync, r_prev} <= 3'b000;
        else        {r_meta, r_sync, r_prev} <= {i_d, r_meta, r_sync};
    end
    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_prev;
endmodule

// File: rtl/addr_stepper.sv
// addr_stepper: walks a memory read address at one of NUM_SPEEDS programmable rates,
// with pause, up/down direction and wrap-or-stop handling at the range ends.
module addr_stepper
    import addr_stepper_pkg::*;
#(
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int DEPTH         = DEF_DEPTH,
    parameter int NUM_SPEEDS    = DEF_NUM_SPEEDS,
    parameter int DEFAULT_SPEED = DEF_DEFAULT_SPEED,
    parameter int BASE_TICKS    = DEF_BASE_TICKS
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           pause,
    input  logic                           speedup,
    input  logic                           speeddown,
    input  logic                           dir,
    input  logic                           wrap_en,
    output logic [ADDR_W-1:0]              addr,
    output logic                           step_pulse,
    output logic [clog2(NUM_SPEEDS)-1:0]   speed_level,
    output logic                           paused,
    output logic                           at_end
);
    localparam int SL_W  = clog2(NUM_SPEEDS);
    localparam int CNT_W = clog2(BASE_TICKS);
    localparam logic [31:0]       BT        = BASE_TICKS;
    localparam logic [SL_W-1:0]   MAX_LVL   = SL_W'(NUM_SPEEDS - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [4:0] w_in, w_lvl, w_rise;
    logic w_unused;
    assign w_in = {wrap_en, dir, speeddown, speedup, pause};
    for (genvar i = 0; i < 5; i++) begin : g_sync
        btn_sync_edge u_sync (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_d    (w_in[i]),
            .o_level(w_lvl[i]),
            .o_rise (w_rise[i])
        );
    end
    // not every control needs both its level and its edge
    assign w_unused = ^{w_lvl, w_rise};

    logic [ADDR_W-1:0] r_addr, w_next;
    logic [SL_W-1:0]   r_lvl;
    logic [CNT_W-1:0]  r_cnt, w_last_cnt;
    logic r_step, r_end, r_dir_q;
    logic w_paused, w_dir, w_wrap, w_inc, w_dec, w_term, w_bound, w_hold, w_clr_end;

    always_comb begin
        w_paused   = w_lvl[0];
        w_dir      = w_lvl[3];
        w_wrap     = w_lvl[4];
        w_inc      = w_rise[1] & ~w_rise[2] & (r_lvl != MAX_LVL);
        w_dec      = w_rise[2] & ~w_rise[1] & (r_lvl != '0);
        w_last_cnt = CNT_W'((BT >> r_lvl) - 32'd1);
        // a level change restarts the period, so it also suppresses a coincident step
        w_term     = ~w_paused & ~w_inc & ~w_dec & (r_cnt == w_last_cnt);
        w_bound    = (w_dir == DIR_DOWN) ? (r_addr == '0) : (r_addr == LAST_ADDR);
        w_hold     = w_bound & ~w_wrap;
        w_next     = (w_dir == DIR_DOWN) ? (w_bound ? LAST_ADDR : r_addr - 1'b1)
                                         : (w_bound ? '0 : r_addr + 1'b1);
        w_clr_end  = (w_dir != r_dir_q) | w_rise[4];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_lvl   <= SL_W'(DEFAULT_SPEED);
            r_cnt   <= '0;
            r_step  <= 1'b0;
            r_end   <= 1'b0;
            r_dir_q <= DIR_UP;
        end else begin
            r_dir_q <= w_dir;
            r_lvl   <= w_inc ? r_lvl + 1'b1 : w_dec ? r_lvl - 1'b1 : r_lvl;
            r_cnt   <= (w_inc | w_dec | w_term) ? '0 : w_paused ? r_cnt : r_cnt + 1'b1;
            r_step  <= w_term & ~w_hold;
            r_addr  <= (w_term & ~w_hold) ? w_next : r_addr;
            r_end   <= w_clr_end ? 1'b0 : (w_term & w_hold) ? 1'b1 : r_end;
        end
    end

    assign addr        = r_addr;
    assign step_pulse  = r_step;
    assign speed_level = r_lvl;
    assign paused      = w_paused;
    assign at_end      = r_end;
endmodule
